loss_unit: RTL and testbench
============================

Name: loss_unit

Overview:
N-column, pipelined loss-gradient unit that sits below the systolic array output, one lane per array column. Each lane computes a loss gradient from prediction H and target Y in signed fixed point, with a run-time mode select: MSE, MAE or Huber. Each lane also accumulates per-batch |H-Y| and emits a batch loss sum, which feeds the training controller's convergence monitor.

Parameters:
N, 2, number of column lanes
DATA_W, 16, signed data width of H, Y, scale, delta and gradient
FRAC_W, 8, fractional bits (Q(DATA_W-FRAC_W).FRAC_W)
ACC_W, 32, unsigned width of batch loss accumulator
CNT_W, 16, width of batch length and per-lane sample counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
H_in  in  N x DATA_W signed  predictions, one per lane
Y_in  in  N x DATA_W signed  targets, one per lane
valid_in  in  N  per-lane sample strobe
mode_in  in  2  0=MSE, 1=MAE, 2=Huber, 3=reserved (behaves as MSE)
scale_in  in  DATA_W signed  gradient scale (e.g. 2/batch for MSE)
delta_in  in  DATA_W signed  Huber clip threshold, non-negative
batch_len_in  in  CNT_W  samples per batch; 0 disables loss reporting
clear_in  in  1  synchronous clear of all accumulators/counters
gradient_out  out  N x DATA_W signed  per-lane gradient
valid_out  out  N  per-lane gradient strobe
loss_sum_out  out  N x ACC_W  per-lane batch sum of |H-Y|
loss_valid_out  out  N  one-cycle pulse per completed batch

Behaviour:
- Reset state (rst_n low, asynchronous): all pipeline registers, counters and accumulators are 0. gradient_out, valid_out, loss_sum_out and loss_valid_out are 0.
- Lanes are fully independent. There is no backpressure. A new sample may be accepted on every cycle per lane.
- Gradient pipeline (fixed latency of 3 cycles from the valid_in edge to valid_out). valid_out[i] is valid_in[i] delayed by 3 cycles.
  - S1: register d = H - Y at DATA_W+1 bits, with no overflow. Capture mode_in, scale_in and delta_in with the sample, so that config changes apply per sample.
  - S2: form operand e.
    - MSE: e = d.
    - MAE: e = +1.0 (1<<FRAC_W) if d>0, -1.0 if d<0, 0 if d==0.
    - Huber: e = clamp(d, -delta, +delta).
  - S3: p = e * scale, full precision. Round half-up (add 1<<(FRAC_W-1)), then arithmetic shift right by FRAC_W. Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Bubble lanes still clock their data. gradient_out holds its last value when valid_out is 0.
- Loss accumulation (per lane, driven from S1):
  - On each valid S1 sample, acc += |d|, saturating at 2^ACC_W-1, and cnt += 1.
  - When the sample makes cnt == batch_len_in: register loss_sum_out = acc + |d| (saturated) and pulse loss_valid_out for 1 cycle. acc and cnt are reset to 0 on the same edge.
  - loss_valid_out therefore fires 2 cycles after valid_in of the final sample. loss_sum_out holds until the next batch completes.
  - batch_len_in == 0: cnt and acc do not advance, and no loss_valid_out is produced.
  - batch_len_in lowered below the current cnt mid-batch: the batch completes on the next valid sample.
- clear_in: zeroes acc and cnt in all lanes. It does not flush the gradient pipeline and does not change loss_sum_out.
  - If clear_in coincides with a valid S1 sample, that sample is counted as the first of a new batch (acc=|d|, cnt=1). If batch_len_in == 1 in that case, the batch completes immediately.
- Reset mid-operation: all in-flight samples are discarded. No valid_out or loss_valid_out is produced for them after rst_n rises.
- Reserved mode 3 behaves exactly as MSE.

Decomposition:
- Shared package (loss_pkg):
  - loss_mode_e enum (MSE, MAE, HUBER, RSVD).
  - Default widths.
  - A function for round-half-up plus saturating narrowing from 2*DATA_W+1 bits to DATA_W bits.
- One sub-module, loss_lane: a single-lane pipeline plus accumulator, instantiated N times under a generate loop.
- The top level only fans out the shared config and slices the packed buses.

Test Plan:
- MSE, lane 0: H=0x0200, Y=0x0100, scale=0x0080 -> gradient_out[0]=0x0080 with valid_out[0] exactly 3 cycles after valid_in.
- MAE and Huber, delta=0x0080, scale=0x0100:
  - MAE with H=0x0100, Y=0x0300 -> 0xFF00.
  - Huber with H=0x0300, Y=0x0100 -> 0x0080.
  - Huber with H=0x0110, Y=0x0100 -> 0x0010.
- Saturation, MSE, scale=0x0100:
  - H=0x7FFF, Y=0x8000 -> 0x7FFF.
  - H=0x8000, Y=0x7FFF -> 0x8000.
- Batch: batch_len=4, lane 1 |d| sequence 0x0100, 0x0080, 0x0040, 0x0040 with gaps between samples -> loss_sum_out[1]=0x00000200, a single-cycle loss_valid_out[1] 2 cycles after the 4th sample, and the next batch starts from 0.
- Config and clear corners:
  - Mode switched every cycle on back-to-back samples -> each output uses its own sample's mode.
  - clear_in coincident with a valid sample -> cnt=1.
  - batch_len=0 -> no loss_valid_out.
- Reset: assert rst_n low with 2 samples in flight -> all outputs 0 immediately (asynchronous), and no valid pulses after release.

Source files
------------

// File: rtl/loss_pkg.sv
// Shared types, default widths and the gradient narrowing helper for the loss unit.
package loss_pkg;

   localparam int LOSS_N      = 2;
   localparam int LOSS_DATA_W = 16;
   localparam int LOSS_FRAC_W = 8;
   localparam int LOSS_ACC_W  = 32;
   localparam int LOSS_CNT_W  = 16;
   localparam int LOSS_PROD_W = 2*LOSS_DATA_W + 1;

   typedef enum logic [1:0] {
      MODE_MSE   = 2'd0,
      MODE_MAE   = 2'd1,
      MODE_HUBER = 2'd2,
      MODE_RSVD  = 2'd3
   } loss_mode_e;

   localparam logic signed [LOSS_PROD_W:0] ROUND_HALF =
      {{(LOSS_PROD_W-LOSS_FRAC_W+1){1'b0}}, 1'b1, {(LOSS_FRAC_W-1){1'b0}}};
   localparam logic signed [LOSS_PROD_W:0] SAT_MAX =
      {{(LOSS_PROD_W-LOSS_DATA_W+2){1'b0}}, {(LOSS_DATA_W-1){1'b1}}};
   localparam logic signed [LOSS_PROD_W:0] SAT_MIN =
      {{(LOSS_PROD_W-LOSS_DATA_W+2){1'b1}}, {(LOSS_DATA_W-1){1'b0}}};

   // Round half-up, drop the fraction bits, then clamp into the signed DATA_W range.
   function automatic logic signed [LOSS_DATA_W-1:0] round_sat(
      input logic signed [LOSS_PROD_W-1:0] p
   );
      logic signed [LOSS_PROD_W:0]   rounded;
      logic signed [LOSS_PROD_W:0]   shifted;
      logic signed [LOSS_DATA_W-1:0] result;
      rounded = $signed({p[LOSS_PROD_W-1], p}) + ROUND_HALF;
      shifted = rounded >>> LOSS_FRAC_W;
      if (shifted > SAT_MAX) begin
         result = SAT_MAX[LOSS_DATA_W-1:0];
      end else if (shifted < SAT_MIN) begin
         result = SAT_MIN[LOSS_DATA_W-1:0];
      end else begin
         result = shifted[LOSS_DATA_W-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/loss_lane.sv
// One column lane: 3-stage gradient pipeline plus the per-batch |H-Y| accumulator.
module loss_lane
   import loss_pkg::*;
#(
   parameter int DATA_W = LOSS_DATA_W,
   parameter int FRAC_W = LOSS_FRAC_W,
   parameter int ACC_W  = LOSS_ACC_W,
   parameter int CNT_W  = LOSS_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] h,
   input  logic signed [DATA_W-1:0] y,
   input  logic                     sample_valid,
   input  loss_mode_e               mode,
   input  logic signed [DATA_W-1:0] scale,
   input  logic signed [DATA_W-1:0] delta,
   input  logic        [CNT_W-1:0]  batch_len,
   input  logic                     clear,
   output logic signed [DATA_W-1:0] gradient,
   output logic                     gradient_valid,
   output logic        [ACC_W-1:0]  loss_sum,
   output logic                     loss_valid
);

   localparam int PROD_W = 2*DATA_W + 1;
   localparam logic signed [DATA_W:0] E_ONE = {{(DATA_W-FRAC_W){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

   logic signed [DATA_W:0]   d_r;
   loss_mode_e               mode1_r;
   logic signed [DATA_W-1:0] scale1_r;
   logic signed [DATA_W-1:0] delta1_r;
   logic                     v1_r;
   logic signed [DATA_W:0]   delta_ext_s;
   logic signed [DATA_W:0]   e_s;
   logic signed [DATA_W:0]   e_r;
   logic signed [DATA_W-1:0] scale2_r;
   logic                     v2_r;
   logic signed [PROD_W-1:0] e_wide_s;
   logic signed [PROD_W-1:0] scale_wide_s;
   logic signed [PROD_W-1:0] p_s;
   logic signed [DATA_W-1:0] grad_r;
   logic                     v3_r;
   logic [DATA_W:0]          abs_d_s;
   logic [ACC_W:0]           sum_wide_s;
   logic [ACC_W-1:0]         base_acc_s;
   logic [ACC_W-1:0]         sum_sat_s;
   logic [ACC_W-1:0]         acc_nxt_s;
   logic [ACC_W-1:0]         acc_r;
   logic [ACC_W-1:0]         lsum_nxt_s;
   logic [ACC_W-1:0]         lsum_r;
   logic [CNT_W-1:0]         base_cnt_s;
   logic [CNT_W-1:0]         cnt_nxt_s;
   logic [CNT_W-1:0]         cnt_r;
   logic [CNT_W:0]           cnt_inc_s;
   logic                     lvalid_nxt_s;
   logic                     lvalid_r;

   // S1: one extra bit keeps H-Y exact; config travels with its sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_r      <= '0;
         mode1_r  <= MODE_MSE;
         scale1_r <= '0;
         delta1_r <= '0;
         v1_r     <= 1'b0;
      end else begin
         d_r      <= {h[DATA_W-1], h} - {y[DATA_W-1], y};
         mode1_r  <= mode;
         scale1_r <= scale;
         delta1_r <= delta;
         v1_r     <= sample_valid;
      end
   end

   // S2 operand selection by the sample's own mode
   always_comb begin
      delta_ext_s = {delta1_r[DATA_W-1], delta1_r};
      e_s         = d_r;
      case (mode1_r)
         MODE_MAE: begin
            if (d_r == '0) begin
               e_s = '0;
            end else if (d_r[DATA_W]) begin
               e_s = -E_ONE;
            end else begin
               e_s = E_ONE;
            end
         end
         MODE_HUBER: begin
            if (d_r > delta_ext_s) begin
               e_s = delta_ext_s;
            end else if (d_r < -delta_ext_s) begin
               e_s = -delta_ext_s;
            end else begin
               e_s = d_r;
            end
         end
         default: e_s = d_r;
      endcase
   end

   // S2 register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_r      <= '0;
         scale2_r <= '0;
         v2_r     <= 1'b0;
      end else begin
         e_r      <= e_s;
         scale2_r <= scale1_r;
         v2_r     <= v1_r;
      end
   end

   // S3 full-precision product
   always_comb begin
      e_wide_s     = {{(PROD_W-DATA_W-1){e_r[DATA_W]}}, e_r};
      scale_wide_s = {{(PROD_W-DATA_W){scale2_r[DATA_W-1]}}, scale2_r};
      p_s          = e_wide_s * scale_wide_s;
   end

   // S3 register: the gradient only moves on a valid sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grad_r <= '0;
         v3_r   <= 1'b0;
      end else begin
         v3_r <= v2_r;
         if (v2_r) begin
            grad_r <= round_sat(p_s);
         end
      end
   end

   // Batch accounting; clear restarts the batch, the S1 sample then counts as its first
   always_comb begin
      if (d_r[DATA_W]) begin
         abs_d_s = -d_r;
      end else begin
         abs_d_s = d_r;
      end
      base_acc_s   = clear ? '0 : acc_r;
      base_cnt_s   = clear ? '0 : cnt_r;
      sum_wide_s   = {1'b0, base_acc_s} + {{(ACC_W-DATA_W){1'b0}}, abs_d_s};
      sum_sat_s    = sum_wide_s[ACC_W] ? '1 : sum_wide_s[ACC_W-1:0];
      cnt_inc_s    = {1'b0, base_cnt_s} + {{CNT_W{1'b0}}, 1'b1};
      acc_nxt_s    = base_acc_s;
      cnt_nxt_s    = base_cnt_s;
      lsum_nxt_s   = lsum_r;
      lvalid_nxt_s = 1'b0;
      if (v1_r && (batch_len != '0)) begin
         if (cnt_inc_s >= {1'b0, batch_len}) begin
            lsum_nxt_s   = sum_sat_s;
            lvalid_nxt_s = 1'b1;
            acc_nxt_s    = '0;
            cnt_nxt_s    = '0;
         end else begin
            acc_nxt_s = sum_sat_s;
            cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
         end
      end else begin
         acc_nxt_s = base_acc_s;
         cnt_nxt_s = base_cnt_s;
      end
   end

   // Accumulator, counter and batch result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r    <= '0;
         cnt_r    <= '0;
         lsum_r   <= '0;
         lvalid_r <= 1'b0;
      end else begin
         acc_r    <= acc_nxt_s;
         cnt_r    <= cnt_nxt_s;
         lsum_r   <= lsum_nxt_s;
         lvalid_r <= lvalid_nxt_s;
      end
   end

   assign gradient       = grad_r;
   assign gradient_valid = v3_r;
   assign loss_sum       = lsum_r;
   assign loss_valid     = lvalid_r;

endmodule

// File: rtl/loss_unit.sv
// N-lane loss-gradient unit: fans the shared configuration out to independent lanes.
module loss_unit
   import loss_pkg::*;
#(
   parameter int N      = LOSS_N,
   parameter int DATA_W = LOSS_DATA_W,
   parameter int FRAC_W = LOSS_FRAC_W,
   parameter int ACC_W  = LOSS_ACC_W,
   parameter int CNT_W  = LOSS_CNT_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N-1:0][DATA_W-1:0]       H_in,
   input  logic [N-1:0][DATA_W-1:0]       Y_in,
   input  logic [N-1:0]                   valid_in,
   input  logic [1:0]                     mode_in,
   input  logic signed [DATA_W-1:0]       scale_in,
   input  logic signed [DATA_W-1:0]       delta_in,
   input  logic [CNT_W-1:0]               batch_len_in,
   input  logic                           clear_in,
   output logic [N-1:0][DATA_W-1:0]       gradient_out,
   output logic [N-1:0]                   valid_out,
   output logic [N-1:0][ACC_W-1:0]        loss_sum_out,
   output logic [N-1:0]                   loss_valid_out
);

   loss_mode_e mode_s;
   assign mode_s = loss_mode_e'(mode_in);

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      loss_lane #(
         .DATA_W (DATA_W),
         .FRAC_W (FRAC_W),
         .ACC_W  (ACC_W),
         .CNT_W  (CNT_W)
      ) u_lane (
         .clk            (clk),
         .rst_n          (rst_n),
         .h              (H_in[gi]),
         .y              (Y_in[gi]),
         .sample_valid   (valid_in[gi]),
         .mode           (mode_s),
         .scale          (scale_in),
         .delta          (delta_in),
         .batch_len      (batch_len_in),
         .clear          (clear_in),
         .gradient       (gradient_out[gi]),
         .gradient_valid (valid_out[gi]),
         .loss_sum       (loss_sum_out[gi]),
         .loss_valid     (loss_valid_out[gi])
      );
   end

endmodule

// File: tb/tb_loss_unit.sv
// Self-checking bench for loss_unit: directed corners plus randomized traffic against an arithmetic model.
module tb_loss_unit;

   localparam int N  = 2;
   localparam int DW = 16;
   localparam int AW = 32;
   localparam int CW = 16;
   localparam longint ACC_MAX = 64'd4294967295;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [N-1:0][DW-1:0]   H_in;
   logic [N-1:0][DW-1:0]   Y_in;
   logic [N-1:0]           valid_in;
   logic [1:0]             mode_in;
   logic signed [DW-1:0]   scale_in;
   logic signed [DW-1:0]   delta_in;
   logic [CW-1:0]          batch_len_in;
   logic                   clear_in;
   logic [N-1:0][DW-1:0]   gradient_out;
   logic [N-1:0]           valid_out;
   logic [N-1:0][AW-1:0]   loss_sum_out;
   logic [N-1:0]           loss_valid_out;

   loss_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .H_in           (H_in),
      .Y_in           (Y_in),
      .valid_in       (valid_in),
      .mode_in        (mode_in),
      .scale_in       (scale_in),
      .delta_in       (delta_in),
      .batch_len_in   (batch_len_in),
      .clear_in       (clear_in),
      .gradient_out   (gradient_out),
      .valid_out      (valid_out),
      .loss_sum_out   (loss_sum_out),
      .loss_valid_out (loss_valid_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Model state: pending gradients with the cycle they are due, batch sums as integers.
   typedef struct {
      int          due;
      logic [15:0] val;
   } pend_t;
   pend_t       gq [N][$];
   logic [15:0] exp_grad [N];
   logic        exp_vout [N];
   logic [31:0] exp_lsum [N];
   logic        exp_lvalid [N];
   longint      m_acc [N];
   longint      m_cnt [N];
   logic        pend_v [N];
   longint      pend_abs [N];

   function automatic logic [15:0] ref_grad(input logic [15:0] h, input logic [15:0] y,
                                            input logic [1:0] mode, input logic [15:0] scale,
                                            input logic [15:0] delta);
      longint d, e, p, r, dl;
      d  = longint'($signed(h)) - longint'($signed(y));
      dl = longint'($signed(delta));
      case (mode)
         2'd1:    e = (d > 0) ? 256 : ((d < 0) ? -256 : 0);
         2'd2:    e = (d > dl) ? dl : ((d < -dl) ? -dl : d);
         default: e = d;
      endcase
      p = e * longint'($signed(scale));
      r = (p + 128) >>> 8;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      return r[15:0];
   endfunction

   function automatic longint abs_diff(input logic [15:0] h, input logic [15:0] y);
      longint d;
      d = longint'($signed(h)) - longint'($signed(y));
      return (d < 0) ? -d : d;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         gq[i].delete();
         exp_grad[i]   = 16'h0;
         exp_vout[i]   = 1'b0;
         exp_lsum[i]   = 32'h0;
         exp_lvalid[i] = 1'b0;
         m_acc[i]      = 0;
         m_cnt[i]      = 0;
         pend_v[i]     = 1'b0;
         pend_abs[i]   = 0;
      end
   endtask

   // Advance one clock edge: update the model from the inputs present at that edge, then sample #1 later.
   task automatic step();
      int nxt;
      nxt = cyc + 1;
      for (int i = 0; i < N; i++) begin
         exp_vout[i] = 1'b0;
         if (gq[i].size() != 0 && gq[i][0].due == nxt) begin
            exp_vout[i] = 1'b1;
            exp_grad[i] = gq[i][0].val;
            void'(gq[i].pop_front());
         end
         if (valid_in[i])
            gq[i].push_back('{due: nxt + 2,
                              val: ref_grad(H_in[i], Y_in[i], mode_in, scale_in, delta_in)});
         exp_lvalid[i] = 1'b0;
         if (clear_in) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
         end
         if (pend_v[i] && batch_len_in != 16'd0) begin
            m_acc[i] = m_acc[i] + pend_abs[i];
            if (m_acc[i] > ACC_MAX) m_acc[i] = ACC_MAX;
            m_cnt[i] = m_cnt[i] + 1;
            if (m_cnt[i] >= longint'(batch_len_in)) begin
               exp_lsum[i]   = m_acc[i][31:0];
               exp_lvalid[i] = 1'b1;
               m_acc[i]      = 0;
               m_cnt[i]      = 0;
            end
         end
         pend_v[i]   = valid_in[i];
         pend_abs[i] = abs_diff(H_in[i], Y_in[i]);
      end
      @(posedge clk);
      cyc = nxt;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (gradient_out[i] !== 16'h0 || valid_out[i] !== 1'b0 ||
             loss_sum_out[i] !== 32'h0 || loss_valid_out[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset lane %0d: grad=%h v=%b sum=%h lv=%b, required all zero",
                     i, gradient_out[i], valid_out[i], loss_sum_out[i], loss_valid_out[i]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mse();
      mode_in = 2'd0; scale_in = 16'sh0080; batch_len_in = 16'd0;
      H_in[0] = 16'h0200; Y_in[0] = 16'h0100; valid_in = 2'b01;
      for (int k = 1; k <= 5; k++) begin
         step();
         valid_in = 2'b00;
         n_checks++;
         if (valid_out[0] !== (k == 3)) begin
            n_fail++;
            $display("FAIL mse_latency cycle %0d: valid_out[0]=%b required %b", k, valid_out[0], (k == 3));
         end
         if (k == 3) begin
            n_checks++;
            if (gradient_out[0] !== 16'h0080) begin
               n_fail++;
               $display("FAIL mse_value: got %h required 0080", gradient_out[0]);
            end
         end
      end
   endtask

   task automatic test_mae_huber();
      logic [15:0] hv[3] = '{16'h0100, 16'h0300, 16'h0110};
      logic [15:0] yv[3] = '{16'h0300, 16'h0100, 16'h0100};
      logic [1:0]  mv[3] = '{2'd1, 2'd2, 2'd2};
      logic [15:0] ev[3] = '{16'hFF00, 16'h0080, 16'h0010};
      scale_in = 16'sh0100; delta_in = 16'sh0080;
      for (int k = 0; k < 5; k++) begin
         if (k < 3) begin
            H_in[0] = hv[k]; Y_in[0] = yv[k]; mode_in = mv[k]; valid_in = 2'b01;
         end else begin
            valid_in = 2'b00;
            mode_in  = 2'd0;
         end
         step();
         if (k >= 2) begin
            n_checks++;
            if (valid_out[0] !== 1'b1 || gradient_out[0] !== ev[k-2]) begin
               n_fail++;
               $display("FAIL mae_huber #%0d: v=%b grad=%h required v=1 grad=%h",
                        k - 2, valid_out[0], gradient_out[0], ev[k-2]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      logic [15:0] hv[3] = '{16'h7FFF, 16'h8000, 16'h0180};
      logic [15:0] yv[3] = '{16'h8000, 16'h7FFF, 16'h0100};
      logic [1:0]  mv[3] = '{2'd0, 2'd0, 2'd3};
      logic [15:0] ev[3] = '{16'h7FFF, 16'h8000, 16'h0080};
      scale_in = 16'sh0100;
      for (int k = 0; k < 5; k++) begin
         if (k < 3) begin
            H_in[0] = hv[k]; Y_in[0] = yv[k]; mode_in = mv[k]; valid_in = 2'b01;
         end else begin
            valid_in = 2'b00;
         end
         step();
         if (k >= 2) begin
            n_checks++;
            if (valid_out[0] !== 1'b1 || gradient_out[0] !== ev[k-2]) begin
               n_fail++;
               $display("FAIL saturation #%0d: v=%b grad=%h required v=1 grad=%h",
                        k - 2, valid_out[0], gradient_out[0], ev[k-2]);
            end
         end
      end
   endtask

   task automatic test_batch();
      logic [15:0] hv[4] = '{16'h0100, 16'h0000, 16'h0040, 16'h0100};
      logic [15:0] yv[4] = '{16'h0000, 16'h0080, 16'h0000, 16'h00C0};
      batch_len_in = 16'd4; mode_in = 2'd0; valid_in = 2'b00; clear_in = 1'b1;
      step();
      clear_in = 1'b0;
      for (int s = 0; s < 4; s++) begin
         H_in[1] = hv[s]; Y_in[1] = yv[s]; valid_in = 2'b10;
         step();
         valid_in = 2'b00;
         for (int g = 0; g < ((s < 3) ? 3 : 1); g++) begin
            n_checks++;
            if (loss_valid_out[1] !== 1'b0) begin
               n_fail++;
               $display("FAIL batch_early sample %0d: loss_valid_out[1]=%b required 0", s, loss_valid_out[1]);
            end
            if (s < 3) step();
         end
      end
      step();
      n_checks++;
      if (loss_valid_out !== 2'b10 || loss_sum_out[1] !== 32'h00000200) begin
         n_fail++;
         $display("FAIL batch_done: lv=%b sum=%h required lv=10 sum=00000200", loss_valid_out, loss_sum_out[1]);
      end
      step();
      n_checks++;
      if (loss_valid_out[1] !== 1'b0 || loss_sum_out[1] !== 32'h00000200) begin
         n_fail++;
         $display("FAIL batch_pulse_width: lv=%b sum=%h required lv=0 sum=00000200", loss_valid_out[1], loss_sum_out[1]);
      end
      H_in[1] = 16'h0010; Y_in[1] = 16'h0000;
      for (int s = 0; s < 4; s++) begin
         valid_in = 2'b10;
         step();
         n_checks++;
         if (loss_valid_out[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL batch2_early sample %0d: lv=%b required 0", s, loss_valid_out[1]);
         end
      end
      valid_in = 2'b00;
      step();
      n_checks++;
      if (loss_valid_out[1] !== 1'b1 || loss_sum_out[1] !== 32'h00000040) begin
         n_fail++;
         $display("FAIL batch2_done: lv=%b sum=%h required lv=1 sum=00000040", loss_valid_out[1], loss_sum_out[1]);
      end
   endtask

   task automatic test_clear();
      batch_len_in = 16'd2; mode_in = 2'd0; valid_in = 2'b00; clear_in = 1'b1;
      step();
      clear_in = 1'b0;
      H_in[0] = 16'h0100; Y_in[0] = 16'h0000; valid_in = 2'b01;
      step();
      H_in[0] = 16'h0020;
      step();
      valid_in = 2'b00; clear_in = 1'b1;
      step();
      clear_in = 1'b0;
      n_checks++;
      if (loss_valid_out[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_restart: lv=%b required 0", loss_valid_out[0]);
      end
      H_in[0] = 16'h0010; valid_in = 2'b01;
      step();
      valid_in = 2'b00;
      step();
      n_checks++;
      if (loss_valid_out[0] !== 1'b1 || loss_sum_out[0] !== 32'h00000030) begin
         n_fail++;
         $display("FAIL clear_count: lv=%b sum=%h required lv=1 sum=00000030", loss_valid_out[0], loss_sum_out[0]);
      end
      batch_len_in = 16'd1; H_in[0] = 16'h0008; valid_in = 2'b01;
      step();
      valid_in = 2'b00; clear_in = 1'b1;
      step();
      clear_in = 1'b0;
      n_checks++;
      if (loss_valid_out[0] !== 1'b1 || loss_sum_out[0] !== 32'h00000008) begin
         n_fail++;
         $display("FAIL clear_len1: lv=%b sum=%h required lv=1 sum=00000008", loss_valid_out[0], loss_sum_out[0]);
      end
   endtask

   task automatic test_len_zero();
      logic [N-1:0][AW-1:0] held;
      step();
      held = loss_sum_out;
      batch_len_in = 16'd0;
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < N; i++) begin
            H_in[i] = 16'($urandom);
            Y_in[i] = 16'($urandom);
         end
         valid_in = (c < 10) ? 2'b11 : 2'b00;
         step();
         n_checks++;
         if (loss_valid_out !== 2'b00 || loss_sum_out !== held) begin
            n_fail++;
            $display("FAIL len_zero cycle %0d: lv=%b sum=%h required lv=00 sum=%h", c, loss_valid_out, loss_sum_out, held);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 0) begin
               H_in[i] = 16'($urandom);
               Y_in[i] = 16'($urandom);
            end else begin
               H_in[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
               Y_in[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
            end
         end
         valid_in = 2'($urandom_range(0, 3));
         mode_in  = 2'($urandom_range(0, 3));
         scale_in = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 511)) - 16'd256;
         delta_in = 16'($urandom_range(0, 32767));
         clear_in = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 19) == 0) batch_len_in = 16'($urandom_range(0, 5));
         step();
         for (int i = 0; i < N; i++) begin
            n_checks++;
            if (valid_out[i] !== exp_vout[i] || gradient_out[i] !== exp_grad[i]) begin
               n_fail++;
               $display("FAIL random_grad cycle %0d lane %0d: v=%b grad=%h required v=%b grad=%h",
                        c, i, valid_out[i], gradient_out[i], exp_vout[i], exp_grad[i]);
            end
            n_checks++;
            if (loss_valid_out[i] !== exp_lvalid[i] || loss_sum_out[i] !== exp_lsum[i]) begin
               n_fail++;
               $display("FAIL random_loss cycle %0d lane %0d: lv=%b sum=%h required lv=%b sum=%h",
                        c, i, loss_valid_out[i], loss_sum_out[i], exp_lvalid[i], exp_lsum[i]);
            end
         end
      end
      clear_in = 1'b0;
   endtask

   task automatic test_reset_flight();
      batch_len_in = 16'd1; mode_in = 2'd0; scale_in = 16'sh0100;
      for (int i = 0; i < N; i++) begin
         H_in[i] = 16'h0100; Y_in[i] = 16'h0000;
      end
      valid_in = 2'b11;
      step();
      step();
      valid_in = 2'b00;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (gradient_out !== '0 || valid_out !== 2'b00 || loss_sum_out !== '0 || loss_valid_out !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_async: grad=%h v=%b sum=%h lv=%b required all zero",
                  gradient_out, valid_out, loss_sum_out, loss_valid_out);
      end
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         n_checks++;
         if (valid_out !== 2'b00 || loss_valid_out !== 2'b00 || gradient_out !== '0) begin
            n_fail++;
            $display("FAIL reset_flush cycle %0d: v=%b lv=%b grad=%h required v=00 lv=00 grad=0",
                     c, valid_out, loss_valid_out, gradient_out);
         end
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      H_in         = '0;
      Y_in         = '0;
      valid_in     = 2'b00;
      mode_in      = 2'd0;
      scale_in     = 16'sh0000;
      delta_in     = 16'sh0000;
      batch_len_in = 16'd0;
      clear_in     = 1'b0;
      model_clear();
      test_reset();
      test_mse();
      test_mae_huber();
      test_saturation();
      test_batch();
      test_clear();
      test_len_zero();
      test_random();
      test_reset_flight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
